// File: rtl/mips_pkg.sv
// Shared MEM-stage types: FSM state encoding, datapath widths and the
// MEM/WB payload record.
package mips_pkg;

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned REG_IDX_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } mem_state_e;

   typedef struct packed {
      logic                 reg_write;
      logic                 mem_to_reg;
      logic [WORD_W-1:0]    alu_out;
      logic [WORD_W-1:0]    rd_data;
      logic [REG_IDX_W-1:0] wn;
   } mem_wb_t;

   // Word accesses must be 4-byte aligned.
   function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM stage and memory.
interface mem_stage_ctrl_if;
   import mips_pkg::*;

   logic              dmem_req;
   logic              dmem_we;
   logic [WORD_W-1:0] dmem_addr;
   logic [WORD_W-1:0] dmem_wdata;
   logic [WORD_W-1:0] dmem_rdata;
   logic              dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );

endinterface

// File: rtl/mem_stage_ctrl_wb_reg.sv
// MEM/WB pipeline register: captures the payload when load is high,
// otherwise inserts an all-zero bubble.
module mem_wb_reg
   import mips_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    load,
   input  mem_wb_t payload_i,
   output mem_wb_t payload_o
);

   mem_wb_t payload_d;
   mem_wb_t payload_q;

   // Select captured payload or bubble.
   always_comb begin
      payload_d = '0;
      if (load) begin
         payload_d = payload_i;
      end
   end

   // Payload register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         payload_q <= '0;
      end else begin
         payload_q <= payload_d;
      end
   end

   assign payload_o = payload_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: data-memory access FSM, pipeline stall, branch/jump redirect
// and the MEM/WB payload register.
module mem_stage_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 BranchMEM,
   input  logic                 MemReadMEM,
   input  logic                 MemWriteMEM,
   input  logic                 RegWriteMEM,
   input  logic                 MemtoRegMEM,
   input  logic                 JumpMEM,
   input  logic                 ZeroMEM,
   input  logic [WORD_W-1:0]    b_tgtMEM,
   input  logic [WORD_W-1:0]    jump_addrMEM,
   input  logic [WORD_W-1:0]    alu_outMEM,
   input  logic [WORD_W-1:0]    rfile_rd2MEM,
   input  logic [REG_IDX_W-1:0] rfile_wnMEM,
   mem_stage_ctrl_if.master     dmem,
   output logic                 en_pipe,
   output logic                 PCSrc,
   output logic [WORD_W-1:0]    pc_tgt,
   output logic                 flush,
   output logic                 RegWriteWB,
   output logic                 MemtoRegWB,
   output logic [WORD_W-1:0]    alu_outWB,
   output logic [WORD_W-1:0]    rd_dataWB,
   output logic [REG_IDX_W-1:0] rfile_wnWB,
   output logic                 mem_err
);

   mem_state_e        state_d,   state_q;
   logic [CNT_W-1:0]  cnt_d,     cnt_q;
   logic [WORD_W-1:0] hold_d,    hold_q;
   logic              acc_err_d, acc_err_q;
   logic              mem_err_d, mem_err_q;

   logic    mem_op;
   logic    wb_load;
   mem_wb_t wb_in;
   mem_wb_t wb_out;

   assign mem_op = MemReadMEM | MemWriteMEM;

   // Next-state, stall and bubble decode for the access FSM.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      acc_err_d = acc_err_q;
      mem_err_d = mem_err_q;
      en_pipe   = 1'b1;
      wb_load   = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (mem_op) begin
               en_pipe   = 1'b0;
               wb_load   = 1'b0;
               cnt_d     = '0;
               acc_err_d = 1'b0;
               if (is_misaligned(alu_outMEM)) begin
                  mem_err_d = 1'b1;
                  acc_err_d = 1'b1;
                  hold_d    = '0;
                  state_d   = ST_DONE;
               end else begin
                  state_d   = ST_ACCESS;
               end
            end
         end
         ST_ACCESS: begin
            en_pipe = 1'b0;
            wb_load = 1'b0;
            if (dmem.dmem_ack) begin
               hold_d  = dmem.dmem_rdata;
               state_d = ST_DONE;
            end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
               mem_err_d = 1'b1;
               acc_err_d = 1'b1;
               hold_d    = '0;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state, wait counter, load-data hold and error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hold_q    <= '0;
         acc_err_q <= 1'b0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         acc_err_q <= acc_err_d;
         mem_err_q <= mem_err_d;
      end
   end

   // A failed access retires without writing the register file.
   always_comb begin
      wb_in            = '0;
      wb_in.reg_write  = RegWriteMEM & ~((state_q == ST_DONE) & acc_err_q);
      wb_in.mem_to_reg = MemtoRegMEM;
      wb_in.alu_out    = alu_outMEM;
      wb_in.rd_data    = hold_q;
      wb_in.wn         = rfile_wnMEM;
   end

   mem_wb_reg u_mem_wb_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (wb_load),
      .payload_i (wb_in),
      .payload_o (wb_out)
   );

   assign RegWriteWB = wb_out.reg_write;
   assign MemtoRegWB = wb_out.mem_to_reg;
   assign alu_outWB  = wb_out.alu_out;
   assign rd_dataWB  = wb_out.rd_data;
   assign rfile_wnWB = wb_out.wn;
   assign mem_err    = mem_err_q;

   assign dmem.dmem_req   = (state_q == ST_ACCESS);
   assign dmem.dmem_we    = (state_q == ST_ACCESS) & MemWriteMEM;
   assign dmem.dmem_addr  = alu_outMEM;
   assign dmem.dmem_wdata = rfile_rd2MEM;

   assign PCSrc  = en_pipe & (JumpMEM | (BranchMEM & ZeroMEM));
   assign flush  = PCSrc;
   assign pc_tgt = JumpMEM ? jump_addrMEM : b_tgtMEM;

endmodule
